booth_accumulator: RTL and testbench

Downstream consumer of the 4x4 Booth multiplier: accepts a stream of signed 8-bit products over a valid/ready handshake and sums each frame of `cfg_len` products into a saturating signed accumulator. It emits one result per frame on a second valid/ready port, so multiplier output becomes a dot-product / MAC result for the next stage.

---
 rtl/booth_pkg.sv | 22 ++
 rtl/sat_adder.sv | 25 ++
 rtl/booth_accumulator.sv | 103 ++++++++++
 tb/tb_booth_accumulator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and limits for the Booth-multiplier accumulator datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 4;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed saturating adder; ovf flags that the result was clamped.
module sat_adder #(
  parameter int W = booth_pkg::ACC_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  import booth_pkg::*;

  localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};
  assign ovf  = wide[W] ^ wide[W-1];

  always_comb begin
    sum = wide[W-1:0];
    if (ovf) sum = wide[W] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/booth_accumulator.sv
// Sums frames of cfg_len signed products into a saturating accumulator and
// presents one registered result per frame on a valid/ready output port.
module booth_accumulator #(
  parameter int PROD_W = booth_pkg::PROD_W,
  parameter int ACC_W  = booth_pkg::ACC_W,
  parameter int LEN_W  = booth_pkg::LEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_sat
);
  import booth_pkg::*;

  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, len_nxt, cnt_nxt, len_first;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_nxt, in_sext, add_sum;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic sat_q, sat_d, sat_nxt, out_sat_q, out_sat_d, add_ovf;
  logic in_take, first_beat;

  assign in_sext    = ACC_W'(in_data);
  assign in_ready   = !clr && ((state_q != HOLD) || out_ready);
  assign in_take    = in_valid && in_ready;
  // Any beat taken outside ACCUM opens a new frame, including back-to-back from HOLD.
  assign first_beat = (state_q != ACCUM);
  assign len_first  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

  sat_adder #(.W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (in_sext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    len_nxt    = first_beat ? len_first : len_q;
    cnt_nxt    = first_beat ? LEN_W'(1) : cnt_q + LEN_W'(1);
    acc_nxt    = first_beat ? in_sext : add_sum;
    sat_nxt    = first_beat ? 1'b0 : (sat_q | add_ovf);

    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else begin
      if (state_q == HOLD && out_ready) state_d = IDLE;
      if (in_take) begin
        len_d = len_nxt;
        cnt_d = cnt_nxt;
        acc_d = acc_nxt;
        sat_d = sat_nxt;
        if (cnt_nxt == len_nxt) begin
          state_d    = HOLD;
          out_data_d = acc_nxt;
          out_sat_d  = sat_nxt;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_booth_accumulator.sv
// Scoreboard bench: two accumulators (16-bit and 10-bit) share one input stream
// and are checked against a frame-level arithmetic reference model.
module tb_booth_accumulator;

  logic clk = 1'b0;
  logic rst, clr, in_valid, out_ready;
  logic [3:0] cfg_len;
  logic signed [7:0] in_data;

  logic in_ready_a, out_valid_a, out_sat_a;
  logic signed [15:0] out_data_a;
  logic in_ready_b, out_valid_b, out_sat_b;
  logic signed [9:0] out_data_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_accumulator #(.PROD_W(8), .ACC_W(16), .LEN_W(4)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_sat(out_sat_a)
  );

  booth_accumulator #(.PROD_W(8), .ACC_W(10), .LEN_W(4)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_sat(out_sat_b)
  );

  typedef struct {
    int d16;
    bit s16;
    int d10;
    bit s10;
  } exp_t;

  exp_t q[$];
  int m_cnt = 0, m_len = 1, m_acc16 = 0, m_acc10 = 0;
  bit m_sat16 = 0, m_sat10 = 0;
  int last16 = 0, last10 = 0, n_popped = 0;
  bit lasts16 = 0, lasts10 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sat_step(input int acc, input int x, input int w, output int r, output bit o);
    int lim;
    lim = 1 << (w - 1);
    r = acc + x;
    o = 1'b0;
    if (r > lim - 1) begin r = lim - 1; o = 1'b1; end
    else if (r < -lim) begin r = -lim; o = 1'b1; end
  endtask

  // Monitor + reference model: sees the values that the next rising edge will sample.
  always @(negedge clk) begin
    bit exp_ir;
    exp_t e;
    int r;
    bit o;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      exp_ir = !clr && (q.size() == 0 || out_ready);
      check("in_ready_w16", in_ready_a, exp_ir);
      check("in_ready_w10", in_ready_b, exp_ir);
      check("out_valid_w16", out_valid_a, q.size() != 0);
      check("out_valid_w10", out_valid_b, q.size() != 0);
      if (q.size() != 0) begin
        e = q[0];
        check("out_data_w16", out_data_a, e.d16);
        check("out_sat_w16", out_sat_a, e.s16);
        check("out_data_w10", out_data_b, e.d10);
        check("out_sat_w10", out_sat_b, e.s10);
      end
      if (clr) begin
        q.delete();
        m_cnt = 0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          e = q.pop_front();
          last16 = e.d16; lasts16 = e.s16;
          last10 = e.d10; lasts10 = e.s10;
          n_popped++;
        end
        if (in_valid && exp_ir) begin
          if (m_cnt == 0) begin
            m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
            m_acc16 = in_data; m_acc10 = in_data;
            m_sat16 = 0; m_sat10 = 0;
          end else begin
            sat_step(m_acc16, in_data, 16, r, o); m_acc16 = r; m_sat16 |= o;
            sat_step(m_acc10, in_data, 10, r, o); m_acc10 = r; m_sat10 |= o;
          end
          m_cnt++;
          if (m_cnt == m_len) begin
            e.d16 = m_acc16; e.s16 = m_sat16; e.d10 = m_acc10; e.s10 = m_sat10;
            q.push_back(e);
            m_cnt = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = 8'(d);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready_a;
      tick();
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no in_ready expected accept of %0d", d);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; cfg_len = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", out_data_a, 0);
    check("rst_out_sat", out_sat_a, 0);
    rst = 1'b0;
    tick();

    cfg_len = 4;
    send(3); send(-5); send(10); send(7);
    tick();
    check("basic_sum", last16, 15);
    check("basic_sat", lasts16, 0);

    cfg_len = 15;
    repeat (15) send(127);
    tick();
    check("satpos_d10", last10, 511);
    check("satpos_s10", lasts10, 1);
    check("satpos_d16", last16, 1905);
    check("satpos_s16", lasts16, 0);
    repeat (15) send(-128);
    tick();
    check("satneg_d10", last10, -512);
    check("satneg_s10", lasts10, 1);
    check("satneg_d16", last16, -1920);

    cfg_len = 2;
    send(1); send(2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'sd3;
    repeat (3) tick();
    check("stall_data", out_data_a, 3);
    check("stall_in_ready", in_ready_a, 0);
    out_ready = 1'b1;
    send(3);
    check("stall_first", last16, 3);
    send(4);
    tick();
    check("stall_second", last16, 7);

    cfg_len = 0;
    p0 = n_popped;
    send(9);
    tick();
    check("len0_first", last16, 9);
    send(-9);
    tick();
    check("len0_second", last16, -9);
    check("len0_count", n_popped - p0, 2);

    cfg_len = 4;
    send(5); send(6);
    p0 = n_popped;
    clr = 1'b1; in_valid = 1'b1; in_data = 8'sd99;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    repeat (4) send(1);
    tick();
    check("clr_sum", last16, 4);
    check("clr_count", n_popped - p0, 1);

    cfg_len = 1; out_ready = 1'b0;
    send(50);
    check("hold_valid", out_valid_a, 1);
    check("hold_data", out_data_a, 50);
    rst = 1'b1;
    #1;
    check("rst_hold_valid", out_valid_a, 0);
    check("rst_hold_data", out_data_a, 0);
    check("rst_hold_data_w10", out_data_b, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    cfg_len = 4;
    send(2); send(2);
    rst = 1'b1;
    #1;
    check("rst_frame_valid", out_valid_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) send(1);
    tick();
    check("rst_frame_sum", last16, 4);

    for (int i = 0; i < 600; i++) begin
      cfg_len   = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
